// File: rtl/rtc_pkg.sv
// Shared definitions for the register-transfer controller: op encodings,
// controller states, default sizing and a small index range helper.
// Optional feature macro: RTC_SWAP_EN (enables the SWAP sequence states).
package rtc_pkg;

   localparam int DEFAULT_WIDTH = 3;
   localparam int DEFAULT_NREG  = 4;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_MOVE  = 2'b01,
      OP_SWAP  = 2'b10,
      OP_LOADI = 2'b11
   } rtc_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_XFER = 3'd1,
`ifdef RTC_SWAP_EN
      ST_SW1  = 3'd2,
      ST_SW2  = 3'd3,
      ST_SW3  = 3'd4,
`endif
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } rtc_state_e;

   // True when a register index addresses a register that actually exists.
   function automatic logic idx_in_range(input logic [31:0] idx, input logic [31:0] nreg);
      return idx < nreg;
   endfunction

endpackage

// File: rtl/rtc_if.sv
// Command/status/read-port bundle between a command source (master) and the
// register-transfer controller (slave).
interface rtc_if
   import rtc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NREG  = DEFAULT_NREG
) ();

   localparam int IDXW = $clog2(NREG);

   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic [IDXW-1:0] req_src;
   logic [IDXW-1:0] req_dst;
   logic [WIDTH-1:0] req_imm;
   logic            busy;
   logic            done;
   logic            err;
   logic [IDXW-1:0] rd_sel;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output req_valid, req_op, req_src, req_dst, req_imm, rd_sel,
      input  req_ready, busy, done, err, rd_data
   );

   modport slave (
      input  req_valid, req_op, req_src, req_dst, req_imm, rd_sel,
      output req_ready, busy, done, err, rd_data
   );

endinterface

// File: rtl/rtc_reg_bank.sv
// Bank of NREG WIDTH-bit registers sharing one write bus. Each register has
// its own load enable; one internal read port feeds the controller's bus and
// one external read port serves rd_sel/rd_data. Out-of-range reads return 0.
module rtc_reg_bank
   import rtc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NREG  = DEFAULT_NREG
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREG-1:0]           load,
   input  logic [WIDTH-1:0]          wr_bus,
   input  logic [$clog2(NREG)-1:0]   bus_sel,
   output logic [WIDTH-1:0]          bus_data,
   input  logic [$clog2(NREG)-1:0]   rd_sel,
   output logic [WIDTH-1:0]          rd_data
);

   localparam int IDXW = $clog2(NREG);

   logic [NREG-1:0][WIDTH-1:0] regs_q;
   logic [NREG-1:0][WIDTH-1:0] regs_d;

   // Next bank contents: a register takes the shared bus only when its load is set.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NREG; i++) begin
         if (load[i]) begin
            regs_d[i] = wr_bus;
         end
      end
   end

   // Bank storage, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read muxes: compare against every legal index so out-of-range selects read as 0.
   always_comb begin
      bus_data = '0;
      rd_data  = '0;
      for (int i = 0; i < NREG; i++) begin
         if (bus_sel == IDXW'(i)) begin
            bus_data = regs_q[i];
         end
         if (rd_sel == IDXW'(i)) begin
            rd_data = regs_q[i];
         end
      end
   end

endmodule

// File: rtl/reg_transfer_ctrl.sv
// Register-transfer controller: accepts one command at a time (NOP, MOVE,
// SWAP, LOADI), latches its operands, range-checks indices and sequences the
// register bank load enables so at most one register is written per cycle.
// Optional feature macro: RTC_SWAP_EN. When undefined, the TMP register and
// the SW1..SW3 states are absent and SWAP is rejected through ERR.
module reg_transfer_ctrl
   import rtc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NREG  = DEFAULT_NREG
) (
   input  logic CLK,
   input  logic RESETn,
   rtc_if.slave bus
);

   localparam int IDXW = $clog2(NREG);

   rtc_state_e       state_q, state_d;
   rtc_op_e          op_q, op_d;
   logic [IDXW-1:0]  src_q, src_d;
   logic [IDXW-1:0]  dst_q, dst_d;
   logic [WIDTH-1:0] imm_q, imm_d;
`ifdef RTC_SWAP_EN
   logic [WIDTH-1:0] tmp_q, tmp_d;
`endif

   logic [NREG-1:0]  load;
   logic [NREG-1:0]  src_onehot;
   logic [NREG-1:0]  dst_onehot;
   logic [WIDTH-1:0] wr_bus;
   logic [WIDTH-1:0] bank_data;
   logic [IDXW-1:0]  bank_sel;
   logic             req_src_ok;
   logic             req_dst_ok;

   rtc_reg_bank #(
      .WIDTH (WIDTH),
      .NREG  (NREG)
   ) u_bank (
      .clk      (CLK),
      .rst_n    (RESETn),
      .load     (load),
      .wr_bus   (wr_bus),
      .bus_sel  (bank_sel),
      .bus_data (bank_data),
      .rd_sel   (bus.rd_sel),
      .rd_data  (bus.rd_data)
   );

   // Index decode: range check of the incoming command and one-hot loads from latched indices.
   always_comb begin
      req_src_ok = idx_in_range(32'(bus.req_src), 32'(NREG));
      req_dst_ok = idx_in_range(32'(bus.req_dst), 32'(NREG));
      src_onehot = '0;
      dst_onehot = '0;
      for (int i = 0; i < NREG; i++) begin
         src_onehot[i] = (src_q == IDXW'(i));
         dst_onehot[i] = (dst_q == IDXW'(i));
      end
   end

   // Controller next state, command latch, bus source select and load enables.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src_d    = src_q;
      dst_d    = dst_q;
      imm_d    = imm_q;
`ifdef RTC_SWAP_EN
      tmp_d    = tmp_q;
`endif
      load     = '0;
      wr_bus   = '0;
      bank_sel = src_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d  = rtc_op_e'(bus.req_op);
               src_d = bus.req_src;
               dst_d = bus.req_dst;
               imm_d = bus.req_imm;
               case (rtc_op_e'(bus.req_op))
                  OP_NOP:   state_d = ST_DONE;
                  OP_MOVE:  state_d = (req_src_ok && req_dst_ok) ? ST_XFER : ST_ERR;
                  OP_LOADI: state_d = req_dst_ok ? ST_XFER : ST_ERR;
`ifdef RTC_SWAP_EN
                  OP_SWAP:  state_d = (req_src_ok && req_dst_ok) ? ST_SW1 : ST_ERR;
`else
                  OP_SWAP:  state_d = ST_ERR;
`endif
                  default:  state_d = ST_ERR;
               endcase
            end
         end
         ST_XFER: begin
            wr_bus  = (op_q == OP_LOADI) ? imm_q : bank_data;
            load    = dst_onehot;
            state_d = ST_DONE;
         end
`ifdef RTC_SWAP_EN
         ST_SW1: begin
            tmp_d   = bank_data;
            state_d = ST_SW2;
         end
         ST_SW2: begin
            bank_sel = dst_q;
            wr_bus   = bank_data;
            load     = src_onehot;
            state_d  = ST_SW3;
         end
         ST_SW3: begin
            wr_bus  = tmp_q;
            load    = dst_onehot;
            state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller state and latched command; reset abandons any sequence in flight.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         src_q   <= '0;
         dst_q   <= '0;
         imm_q   <= '0;
`ifdef RTC_SWAP_EN
         tmp_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         imm_q   <= imm_d;
`ifdef RTC_SWAP_EN
         tmp_q   <= tmp_d;
`endif
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = (state_q == ST_ERR);

endmodule
